// File: rtl/ibex_stim_gen.sv
// ibex_stim_gen -- multi-channel pseudo-random stimulus generator.
//
// A run starts with a start_i pulse in IDLE or DONE. The generator then holds
// the DUT in reset for RST_CYCLES cycles and issues RUN_CYCLES stimulus vectors.
// Each vector is produced by NUM_CH independent 32-bit Galois LFSRs.
//
// Parameters:
//   NUM_CH     number of stimulus channels (1..8)
//   CH_W       channel width in bits (1..32)
//   RST_CYCLES cycles dut_rst_no is held low in RESET (>= 1)
//   RUN_CYCLES vectors issued per run (>= 1)
//   SEED       power-up base seed
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            begin a run (IDLE/DONE only)
//   hold_i             pause stimulus advance while in RUN
//   seed_load_i/seed_i load a new base seed (IDLE/DONE only)
//   dut_rst_no         active-low reset for the DUT
//   stim_o             channel k at bits [k*CH_W +: CH_W]
//   stim_valid_o       stim_o carries a new vector this cycle
//   done_o             run complete
//   state_o            IDLE=0, RESET=1, RUN=2, DONE=3
//   vec_cnt_o          vectors issued in the current run
//   cksum_o            rolling checksum of the issued vectors
//
// Configuration macro: IBEX_STIM_GEN_CKSUM_EN enables the checksum register;
// without it cksum_o is tied to zero.
//
// Stimulus handshake: stim_valid_o is a pure valid strobe with no ready.
// A vector is consumed on every cycle where stim_valid_o=1. The consumer cannot
// apply back-pressure except through hold_i, which drops stim_valid_o and
// freezes stim_o in the same cycle.
module ibex_stim_gen #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 32,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned RUN_CYCLES = 1000,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     hold_i,
    input  logic                     seed_load_i,
    input  logic [31:0]              seed_i,
    output logic                     dut_rst_no,
    output logic [NUM_CH*CH_W-1:0]   stim_o,
    output logic                     stim_valid_o,
    output logic                     done_o,
    output logic [1:0]               state_o,
    output logic [31:0]              vec_cnt_o,
    output logic [31:0]              cksum_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] base_seed_q;
    logic [31:0] seed_eff;
    logic [31:0] rst_cnt_q;
    logic [31:0] vec_cnt_q;
    logic        idle_or_done;
    logic        launch;
    logic        advance;
    logic        last_vec;
    logic        rst_last;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign launch       = idle_or_done && start_i;
    // A seed loaded together with start_i must seed that same run.
    assign seed_eff     = (idle_or_done && seed_load_i) ? seed_i : base_seed_q;
    assign advance      = (state_q == ST_RUN) && !hold_i;
    assign last_vec     = (vec_cnt_q == 32'(RUN_CYCLES - 1));
    assign rst_last     = (rst_cnt_q == 32'(RST_CYCLES - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        dut_rst_no   = 1'b0;
        done_o       = 1'b0;
        stim_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (rst_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                dut_rst_no   = 1'b1;
                stim_valid_o = !hold_i;
                if (advance && last_vec) state_d = ST_DONE;
            end
            ST_DONE: begin
                dut_rst_no = 1'b1;
                done_o     = 1'b1;
                if (start_i) state_d = ST_RESET;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o   = state_q;
    assign vec_cnt_o = vec_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_seed_q <= SEED;
        end else if (idle_or_done && seed_load_i) begin
            base_seed_q <= seed_i;
        end
    end

    // Counts the cycles spent in RESET; cleared whenever a run is launched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt_q <= 32'h0;
        end else if (launch) begin
            rst_cnt_q <= 32'h0;
        end else if (state_q == ST_RESET) begin
            rst_cnt_q <= rst_cnt_q + 32'h1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec_cnt_q <= 32'h0;
        end else if (launch) begin
            vec_cnt_q <= 32'h0;
        end else if (advance) begin
            vec_cnt_q <= vec_cnt_q + 32'h1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Golden-ratio spread so that channels sharing one base seed diverge.
        localparam logic [31:0] MIX = 32'(k) * 32'h9E37_79B9;
        logic [31:0] seed_mix;
        logic [31:0] seed_k;
        logic [31:0] lfsr_q;

        assign seed_mix = seed_eff ^ MIX;
        // An all-zero LFSR would lock up, so zero seeds become 1.
        assign seed_k   = (seed_mix == 32'h0) ? 32'h1 : seed_mix;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lfsr_q <= 32'h0;
            end else if (launch) begin
                lfsr_q <= seed_k;
            end else if (advance) begin
                lfsr_q <= lfsr_step(lfsr_q);
            end
        end

        assign stim_o[k*CH_W +: CH_W] = lfsr_q[CH_W-1:0];
    end

`ifdef IBEX_STIM_GEN_CKSUM_EN
    logic [31:0] cksum_q;
    logic [31:0] ch_xor;

    always_comb begin
        ch_xor = 32'h0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            ch_xor = ch_xor ^ 32'(stim_o[k*CH_W +: CH_W]);
        end
    end

    // Rotate-left then fold in the vector being presented on this advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cksum_q <= 32'h0;
        end else if (launch) begin
            cksum_q <= 32'h0;
        end else if (advance) begin
            cksum_q <= {cksum_q[30:0], cksum_q[31]} ^ ch_xor;
        end
    end

    assign cksum_o = cksum_q;
`else
    assign cksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_ibex_stim_gen.sv
// Testbench for ibex_stim_gen.
// Instance "dut" (2 x 8-bit channels, 4 vectors per run) is checked every cycle
// against a behavioural model. It also gets directed scenarios with literal
// expectations.
// Instance "dut_b" (1 x 32-bit channel, 2 vectors per run) pins the
// checksum values.
module tb_ibex_stim_gen;

    localparam int NUM_CH     = 2;
    localparam int CH_W       = 8;
    localparam int RST_CYCLES = 2;
    localparam int RUN_CYCLES = 4;
    localparam int SW         = NUM_CH * CH_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          seed_load = 1'b0;
    logic [31:0]   seed = 32'h0;
    logic          dut_rst_n;
    logic [SW-1:0] stim;
    logic          stim_valid;
    logic          done;
    logic [1:0]    state;
    logic [31:0]   vec_cnt;
    logic [31:0]   cksum;

    ibex_stim_gen #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .RST_CYCLES(RST_CYCLES),
        .RUN_CYCLES(RUN_CYCLES), .SEED(32'h1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold),
        .seed_load_i(seed_load), .seed_i(seed), .dut_rst_no(dut_rst_n),
        .stim_o(stim), .stim_valid_o(stim_valid), .done_o(done),
        .state_o(state), .vec_cnt_o(vec_cnt), .cksum_o(cksum)
    );

    // ---------------- DUT B (checksum pinning) ----------------
    logic        start_b = 1'b0;
    logic        b_dut_rst_n;
    logic [31:0] b_stim;
    logic        b_valid;
    logic        b_done;
    logic [1:0]  b_state;
    logic [31:0] b_vec;
    logic [31:0] b_cksum;

    ibex_stim_gen #(
        .NUM_CH(1), .CH_W(32), .RST_CYCLES(2), .RUN_CYCLES(2), .SEED(32'h1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .hold_i(1'b0),
        .seed_load_i(1'b0), .seed_i(32'h0), .dut_rst_no(b_dut_rst_n),
        .stim_o(b_stim), .stim_valid_o(b_valid), .done_o(b_done),
        .state_o(b_state), .vec_cnt_o(b_vec), .cksum_o(b_cksum)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of DUT A ----------------
    // State numbering follows the state_o encoding (0 idle, 1 reset, 2 run, 3 done).
    logic [1:0]  m_state;
    logic [31:0] m_lfsr [NUM_CH];
    logic [31:0] m_base;
    logic [31:0] m_vec;
    logic [31:0] m_ck;
    int          m_rst_left;

    function automatic logic [31:0] next_lfsr(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base ^ (32'(k) * 32'h9E37_79B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [SW-1:0] model_stim();
        logic [SW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*CH_W +: CH_W] = m_lfsr[k][CH_W-1:0];
        return v;
    endfunction

    task automatic model_reset();
        m_state    = 2'd0;
        m_base     = 32'h1;
        m_vec      = 32'h0;
        m_ck       = 32'h0;
        m_rst_left = 0;
        for (int k = 0; k < NUM_CH; k++) m_lfsr[k] = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] x;
        case (m_state)
            2'd0, 2'd3: begin
                if (seed_load) m_base = seed;
                if (start) begin
                    for (int k = 0; k < NUM_CH; k++) m_lfsr[k] = chan_seed(m_base, k);
                    m_vec      = 32'h0;
                    m_ck       = 32'h0;
                    m_rst_left = RST_CYCLES;
                    m_state    = 2'd1;
                end
            end
            2'd1: begin
                m_rst_left--;
                if (m_rst_left == 0) m_state = 2'd2;
            end
            default: begin
                if (!hold) begin
                    x = 32'h0;
                    for (int k = 0; k < NUM_CH; k++) x ^= 32'(m_lfsr[k][CH_W-1:0]);
                    m_ck = {m_ck[30:0], m_ck[31]} ^ x;
                    for (int k = 0; k < NUM_CH; k++) m_lfsr[k] = next_lfsr(m_lfsr[k]);
                    m_vec++;
                    if (m_vec == RUN_CYCLES) m_state = 2'd3;
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        logic [31:0] exp_ck;
        forever begin
            @(negedge clk);
`ifdef IBEX_STIM_GEN_CKSUM_EN
            exp_ck = m_ck;
`else
            exp_ck = 32'h0;
`endif
            chk("state", state, m_state);
            chk("dut_rst_n", dut_rst_n, (m_state == 2'd2) || (m_state == 2'd3));
            chk("stim", stim, model_stim());
            chk("stim_valid", stim_valid, (m_state == 2'd2) && !hold);
            chk("done", done, m_state == 2'd3);
            chk("vec_cnt", vec_cnt, m_vec);
            chk("cksum", cksum, exp_ck);
        end
    end

    // ---------------- scoreboard: issued-vector capture ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] got1_q[$];
    int         rst_low_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (stim_valid === 1'b1) begin
                got_q.push_back(stim[7:0]);
                got1_q.push_back(stim[15:8]);
            end
            if (state === 2'd1 && dut_rst_n === 1'b0) rst_low_cnt++;
        end
    end

    task automatic clear_capture();
        got_q.delete();
        got1_q.delete();
        rst_low_cnt = 0;
    endtask

    task automatic seq_check(input string name, input logic [7:0] ch1_first);
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_ch0_v%0d", name, i), got_q[i], exp_q[i]);
        if (got1_q.size() > 0) chk({name, "_ch1_first"}, got1_q[0], ch1_first);
        else chk({name, "_ch1_present"}, 0, 1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic ld, input logic [31:0] s);
        @(posedge clk); #1;
        start = 1'b1; seed_load = ld; seed = s;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 100) begin @(negedge clk); i++; end
        chk(name, done, 1'b1);
    endtask

    task automatic wait_vec(input logic [31:0] v, input string name);
        int i;
        i = 0;
        while (vec_cnt !== v && i < 100) begin @(negedge clk); i++; end
        chk(name, vec_cnt, v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h01};

        // Reset values while rst_n is held low
        @(negedge clk);
        chk("rst_state", state, 2'd0);
        chk("rst_dut_rst_n", dut_rst_n, 1'b0);
        chk("rst_stim", stim, 16'h0);
        chk("rst_valid", stim_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_vec", vec_cnt, 32'h0);
        chk("rst_cksum", cksum, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic run
        clear_capture();
        pulse_start(1'b0, 32'h0);
        wait_done("basic_done");
        chk("basic_vec", vec_cnt, 32'd4);
        chk("basic_rst_cycles", rst_low_cnt, 2);
        seq_check("basic", 8'hB8);

        // Hold for 3 cycles mid-run
        clear_capture();
        pulse_start(1'b0, 32'h0);
        wait_vec(32'd2, "hold_reach");
        @(posedge clk); #1 hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", stim_valid, 1'b0);
            chk("hold_vec", vec_cnt, 32'd3);
            chk("hold_stim_ch0", stim[7:0], 8'h01);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        wait_done("hold_done");
        seq_check("hold", 8'hB8);

        // Zero seed loaded with start from DONE
        clear_capture();
        pulse_start(1'b1, 32'h0);
        wait_done("zseed_done");
        seq_check("zseed", 8'hB9);

        // Checksum pinning on dut_b
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 20 && b_vec !== 32'd1; i++) @(negedge clk);
        chk("b_vec1", b_vec, 32'd1);
        chk("b_stim1", b_stim, 32'h8020_0003);
`ifdef IBEX_STIM_GEN_CKSUM_EN
        chk("b_cksum1", b_cksum, 32'h0000_0001);
`else
        chk("b_cksum1", b_cksum, 32'h0);
`endif
        for (int i = 0; i < 20 && b_vec !== 32'd2; i++) @(negedge clk);
        chk("b_vec2", b_vec, 32'd2);
        chk("b_done", b_done, 1'b1);
`ifdef IBEX_STIM_GEN_CKSUM_EN
        chk("b_cksum2", b_cksum, 32'h8020_0001);
`else
        chk("b_cksum2", b_cksum, 32'h0);
`endif

        // Asynchronous reset mid-run
        clear_capture();
        pulse_start(1'b0, 32'h0);
        wait_vec(32'd2, "arst_reach");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 2'd0);
        chk("arst_dut_rst_n", dut_rst_n, 1'b0);
        chk("arst_stim", stim, 16'h0);
        chk("arst_valid", stim_valid, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_vec", vec_cnt, 32'h0);
        chk("arst_cksum", cksum, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_capture();
        pulse_start(1'b0, 32'h0);
        wait_done("arst_rerun_done");
        seq_check("arst_rerun", 8'hB8);

        // Randomised phase: model compare covers every cycle
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            start     = ($urandom_range(0, 7) == 0);
            seed_load = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: seed = 32'h0;
                1: seed = 32'h9E37_79B9;
                default: seed = $urandom;
            endcase
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; seed_load = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_stim_gen.md
IBEX_STIM_GEN -- requirements
Module: ibex_stim_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent stimulus channels (legal range 1..8).
REQ-002 SHALL have parameter CH_W, default 32, meaning the channel width in bits (legal range 1..32).
REQ-003 SHALL have parameter RST_CYCLES, default 2, meaning the number of cycles the DUT reset is held low (minimum 1).
REQ-004 SHALL have parameter RUN_CYCLES, default 1000, meaning the number of stimulus vectors issued per run (minimum 1).
REQ-005 SHALL have parameter SEED, default 32'h1, meaning the power-up seed for channel 0.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start_i, input, 1 bit: begins a run from IDLE or DONE.
REQ-009 SHALL have port hold_i, input, 1 bit: pauses stimulus advance while in RUN.
REQ-010 SHALL have port seed_load_i, input, 1 bit: loads seed_i as the base seed.
REQ-011 SHALL have port seed_i, input, 32 bits: the runtime seed value.
REQ-012 SHALL have port dut_rst_no, output, 1 bit: the active-low reset driven to the DUT.
REQ-013 SHALL have port stim_o, output, NUM_CH*CH_W bits: channel k occupies bits [k*CH_W +: CH_W].
REQ-014 SHALL have port stim_valid_o, output, 1 bit: stim_o carries a new vector this cycle.
REQ-015 SHALL have port done_o, output, 1 bit: the run is complete.
REQ-016 SHALL have port state_o, output, 2 bits: IDLE=0, RESET=1, RUN=2, DONE=3.
REQ-017 SHALL have port vec_cnt_o, output, 32 bits: the number of vectors issued in the current run.
REQ-018 SHALL have port cksum_o, output, 32 bits: the stimulus checksum (see REQ-031).

Function
REQ-019 SHALL implement a 4-state FSM with states IDLE, RESET, RUN, DONE.
REQ-020 SHALL move IDLE->RESET or DONE->RESET on the cycle after start_i=1 is sampled.
REQ-021 SHALL, on entry to RESET: load every channel LFSR with base_seed ^ (k*32'h9E3779B9); clear vec_cnt_o; clear cksum_o. Any resulting zero seed SHALL be replaced by 32'h1.
REQ-022 SHALL drive dut_rst_no=0 in IDLE and for exactly RST_CYCLES cycles in RESET, then move to RUN; dut_rst_no=1 in RUN and DONE.
REQ-023 SHALL step each channel LFSR per cycle as a 32-bit Galois right shift: next = lsb ? (x>>1)^32'h80200003 : x>>1.
REQ-024 SHALL drive stim_o[k] as the low CH_W bits of LFSR k; the first RUN cycle presents the seed values.
REQ-025 SHALL define advance = (state==RUN && !hold_i); on advance: stim_valid_o=1, all LFSRs step, vec_cnt_o increments.
REQ-026 SHALL hold LFSRs and vec_cnt_o frozen and drive stim_valid_o=0 when hold_i=1 in RUN.
REQ-027 SHALL move RUN->DONE when advance occurs with vec_cnt_o==RUN_CYCLES-1; done_o=1 only in DONE; stim_o held stable in DONE.
REQ-028 SHALL load seed_i into base_seed on seed_load_i=1 only in IDLE or DONE; it is ignored in RESET/RUN. If seed_load_i and start_i are simultaneous, the new seed is used by that run.
REQ-029 SHALL give start_i no effect in RESET/RUN; hold_i has no effect outside RUN.

Reset
REQ-030 SHALL, on rst_ni=0 (any state, including mid-run), immediately set state IDLE, base_seed=SEED, LFSRs=0, stim_o=0, stim_valid_o=0, done_o=0, dut_rst_no=0, vec_cnt_o=0, cksum_o=0.

Configuration
REQ-031 SHALL, with macro IBEX_STIM_GEN_CKSUM_EN defined, update cksum_o on every advance to {cksum_o[30:0],cksum_o[31]} ^ XOR of all channels zero-extended to 32 bits; without the macro, cksum_o SHALL be constant 0 and no checksum register exists.

Verification
REQ-032 SHALL cover: NUM_CH=2, CH_W=8, RST_CYCLES=2, RUN_CYCLES=4, SEED=1, start_i pulse -> dut_rst_no low 2 cycles in RESET; ch0 presents 0x01, 0x03, then next two LFSR values; done_o=1 after 4 valids; vec_cnt_o=4.
REQ-033 SHALL cover: same config, hold_i=1 for 3 cycles mid-RUN -> stim_valid_o=0 and stim_o/vec_cnt_o frozen for those 3 cycles; run ends after exactly 4 valid vectors.
REQ-034 SHALL cover: in DONE, seed_load_i=1 with seed_i=0 plus start_i -> ch0 seed substituted to 0x01; the sequence is identical to REQ-032.
REQ-035 SHALL cover: rst_ni pulled low at vec_cnt_o=2 -> all outputs reset asynchronously, state_o=0; a subsequent start reproduces the REQ-032 sequence.
REQ-036 SHALL cover: with IBEX_STIM_GEN_CKSUM_EN, NUM_CH=1, CH_W=32, SEED=1, RUN_CYCLES=2 -> cksum_o=0x00000001 after vector 1 and 0x80200001 after vector 2; without the macro, cksum_o=0 throughout.
